// File: rtl/gray_step_checker.sv
`default_nettype none
// ============================================================================
// Module   : gray_step_checker
// Purpose  : Decodes valid Gray samples to binary, flags +/-1 steps and
//            illegal jumps, counts errors and declares lock after a clean run.
//            Optional build macro GRAY_ERR_HOLD_EN: hold BIN/ref on errors.
// Revision : 1.0 - initial release
// ============================================================================
module gray_step_checker #(
    parameter int WIDTH    = 4,
    parameter int ERR_W    = 8,
    parameter int LOCK_CNT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] G,
    input  logic             g_valid,
    input  logic             clear,
    output logic [WIDTH-1:0] BIN,
    output logic             bin_valid,
    output logic             dir_up,
    output logic             dir_down,
    output logic             step_err,
    output logic [ERR_W-1:0] err_count,
    output logic             locked
);

    localparam int                 c_RUN_W   = 8;
    localparam logic [WIDTH-1:0]   c_ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [c_RUN_W-1:0] c_RUN_ONE = {{(c_RUN_W-1){1'b0}}, 1'b1};
    localparam logic [c_RUN_W-1:0] c_LOCK    = c_RUN_W'(LOCK_CNT);
    localparam logic [ERR_W-1:0]   c_ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0]   c_ERR_MAX = {ERR_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [WIDTH-1:0]    r_ref, w_ref_nxt;
    logic [WIDTH-1:0]    w_bin, w_bin_nxt;
    logic [WIDTH-1:0]    w_ref_inc, w_ref_dec;
    logic [c_RUN_W-1:0]  r_run, w_run_nxt;
    logic [ERR_W-1:0]    w_err_nxt;
    logic                w_bv, w_up, w_dn, w_se;

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        w_bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_bin[i] = ^(G >> i);
        end
    end

    assign w_ref_inc = r_ref + c_ONE;
    assign w_ref_dec = r_ref - c_ONE;

    always_comb begin
        w_state_nxt = r_state;
        w_ref_nxt   = r_ref;
        w_bin_nxt   = BIN;
        w_run_nxt   = r_run;
        w_err_nxt   = err_count;
        w_bv        = 1'b0;
        w_up        = 1'b0;
        w_dn        = 1'b0;
        w_se        = 1'b0;

        if (clear) begin
            w_state_nxt = ST_IDLE;
            w_run_nxt   = '0;
            w_err_nxt   = '0;
        end else if (g_valid) begin
            w_bv = 1'b1;
            if (r_state == ST_IDLE) begin
                w_ref_nxt   = w_bin;
                w_bin_nxt   = w_bin;
                w_run_nxt   = '0;
                w_state_nxt = ST_TRACK;
            end else if (w_bin != r_ref) begin
                if ((w_bin == w_ref_inc) || (w_bin == w_ref_dec)) begin
                    w_up      = (w_bin == w_ref_inc);
                    w_dn      = (w_bin != w_ref_inc);
                    w_ref_nxt = w_bin;
                    w_bin_nxt = w_bin;
                    if (r_state == ST_TRACK) begin
                        w_run_nxt = r_run + c_RUN_ONE;
                        if ((r_run + c_RUN_ONE) == c_LOCK) begin
                            w_state_nxt = ST_LOCKED;
                        end
                    end
                end else begin
                    w_se        = 1'b1;
                    w_run_nxt   = '0;
                    w_state_nxt = ST_TRACK;
                    if (err_count != c_ERR_MAX) begin
                        w_err_nxt = err_count + c_ERR_ONE;
                    end
`ifndef GRAY_ERR_HOLD_EN
                    // Resynchronise tracking to the offending code.
                    w_ref_nxt = w_bin;
                    w_bin_nxt = w_bin;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_ref     <= '0;
            r_run     <= '0;
            BIN       <= '0;
            bin_valid <= 1'b0;
            dir_up    <= 1'b0;
            dir_down  <= 1'b0;
            step_err  <= 1'b0;
            err_count <= '0;
            locked    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ref     <= w_ref_nxt;
            r_run     <= w_run_nxt;
            BIN       <= w_bin_nxt;
            bin_valid <= w_bv;
            dir_up    <= w_up;
            dir_down  <= w_dn;
            step_err  <= w_se;
            err_count <= w_err_nxt;
            locked    <= (w_state_nxt == ST_LOCKED);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gray_step_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_gray_step_checker
// Purpose  : Directed and randomized bench for gray_step_checker against a
//            modular-arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gray_step_checker;

    localparam int W    = 4;
    localparam int LOCK = 4;
    localparam int MODV = 1 << W;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] G;
    logic         g_valid;
    logic         clear;

    logic [W-1:0] bin, bin_s;
    logic         bin_valid, dir_up, dir_down, step_err, locked;
    logic         bin_valid_s, dir_up_s, dir_down_s, step_err_s, locked_s;
    logic [7:0]   err_count;
    logic [1:0]   err_count_s;

    int total = 0;
    int bad   = 0;

    // reference model state
    bit m_idle, m_locked, m_bv, m_up, m_dn, m_se;
    int m_run, m_ref, m_bin, m_err8, m_err2;

    gray_step_checker #(.WIDTH(W), .ERR_W(8), .LOCK_CNT(LOCK)) dut (
        .clk(clk), .rst_n(rst_n), .G(G), .g_valid(g_valid), .clear(clear),
        .BIN(bin), .bin_valid(bin_valid), .dir_up(dir_up), .dir_down(dir_down),
        .step_err(step_err), .err_count(err_count), .locked(locked)
    );

    gray_step_checker #(.WIDTH(W), .ERR_W(2), .LOCK_CNT(LOCK)) dut_s (
        .clk(clk), .rst_n(rst_n), .G(G), .g_valid(g_valid), .clear(clear),
        .BIN(bin_s), .bin_valid(bin_valid_s), .dir_up(dir_up_s), .dir_down(dir_down_s),
        .step_err(step_err_s), .err_count(err_count_s), .locked(locked_s)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] gray_of(input int b);
        logic [W-1:0] v;
        v = W'(b);
        return v ^ (v >> 1);
    endfunction

    // Inverse by search over the encoder's codebook.
    function automatic int decode(input logic [W-1:0] g);
        for (int v = 0; v < MODV; v++) begin
            if (gray_of(v) == g) return v;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_idle = 1; m_locked = 0; m_run = 0; m_ref = 0; m_bin = 0;
        m_err8 = 0; m_err2 = 0; m_bv = 0; m_up = 0; m_dn = 0; m_se = 0;
    endtask

    task automatic model_step(input bit c, input bit v, input logic [W-1:0] g);
        int b, d;
        m_bv = 0; m_up = 0; m_dn = 0; m_se = 0;
        if (c) begin
            m_idle = 1; m_locked = 0; m_run = 0; m_err8 = 0; m_err2 = 0;
        end else if (v) begin
            b    = decode(g);
            m_bv = 1;
            if (m_idle) begin
                m_idle = 0; m_ref = b; m_bin = b; m_run = 0;
            end else begin
                d = (b - m_ref + MODV) % MODV;
                if (d == 1 || d == MODV - 1) begin
                    m_up = (d == 1); m_dn = (d != 1);
                    m_ref = b; m_bin = b;
                    if (!m_locked) begin
                        m_run++;
                        if (m_run >= LOCK) m_locked = 1;
                    end
                end else if (d != 0) begin
                    m_se = 1; m_run = 0; m_locked = 0;
                    if (m_err8 < 255) m_err8++;
                    if (m_err2 < 3) m_err2++;
`ifndef GRAY_ERR_HOLD_EN
                    m_ref = b; m_bin = b;
`endif
                end
            end
        end
    endtask

    task automatic compare_all(input string where);
        check_value({where, ".BIN"},       bin,         m_bin);
        check_value({where, ".bin_valid"}, bin_valid,   m_bv);
        check_value({where, ".dir_up"},    dir_up,      m_up);
        check_value({where, ".dir_down"},  dir_down,    m_dn);
        check_value({where, ".step_err"},  step_err,    m_se);
        check_value({where, ".err_count"}, err_count,   m_err8);
        check_value({where, ".err_sat"},   err_count_s, m_err2);
        check_value({where, ".locked"},    locked,      m_locked);
    endtask

    task automatic drive(input string where, input bit c, input bit v, input logic [W-1:0] g);
        clear = c; g_valid = v; G = g;
        @(posedge clk);
        #1;
        model_step(c, v, g);
        compare_all(where);
    endtask

    task automatic sample(input string where, input int b);
        drive(where, 1'b0, 1'b1, gray_of(b));
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; g_valid = 1'b1; G = 4'b0110;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        @(negedge clk);
        g_valid = 1'b0;
        rst_n   = 1'b1;

        // Up sequence to lock
        drive("up0", 0, 1, 4'b0000);
        drive("up1", 0, 1, 4'b0001);
        drive("up2", 0, 1, 4'b0011);
        drive("up3", 0, 1, 4'b0010);
        drive("up4", 0, 1, 4'b0110);
        check_value("up_bin4", bin, 4);
        check_value("up_lock", locked, 1);

        // clear together with g_valid discards the sample
        drive("clr", 1, 1, 4'b0111);
        check_value("clr_bv", bin_valid, 0);

        // Wrap and down
        drive("wr0", 0, 1, 4'b1000);
        check_value("wr_ref_bin", bin, 15);
        drive("wr1", 0, 1, 4'b0000);
        check_value("wr_up", dir_up, 1);
        drive("wr2", 0, 1, 4'b1000);
        check_value("wr_down", dir_down, 1);
        check_value("wr_noerr", step_err, 0);

        // Lock through wrap at 13,14,15,0,1 then jump to 6
        drive("lk_clr", 1, 0, 4'b0000);
        sample("lk0", 13); sample("lk1", 14); sample("lk2", 15);
        sample("lk3", 0);  sample("lk4", 1);
        check_value("lk_locked", locked, 1);
        drive("lk_err", 0, 1, 4'b0101);
        check_value("lk_step_err", step_err, 1);
        check_value("lk_err_count", err_count, 1);
        check_value("lk_unlock", locked, 0);
`ifdef GRAY_ERR_HOLD_EN
        check_value("lk_bin_hold", bin, 1);
`else
        check_value("lk_bin_new", bin, 6);
`endif

        // Saturation of the 2-bit counter: 1,2,3,3,3
        drive("sat_clr", 1, 0, 4'b0000);
        sample("sat_ref", 0);
        for (int i = 0; i < 5; i++) begin
            sample("sat", (i % 2 == 0) ? 8 : 0);
            check_value("sat_seq", err_count_s, (i < 3) ? i + 1 : 3);
        end

        // Reset mid-sequence, then resume with 0110
        sample("pre_rst", 1);
        g_valid = 1'b1; G = 4'b0011;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("rst_low");
        @(posedge clk);
        #1;
        compare_all("rst_held");
        @(negedge clk);
        g_valid = 1'b0;
        rst_n   = 1'b1;
        drive("resume", 0, 1, 4'b0110);
        check_value("resume_bin", bin, 4);
        check_value("resume_dir", {dir_up, dir_down, step_err}, 0);

        // Randomized: mostly legal steps with occasional jumps, gaps and clears
        for (int n = 0; n < 1500; n++) begin
            int r, b;
            bit c, v;
            r = int'($urandom_range(0, 9));
            if (r < 3)      b = (m_ref + 1) % MODV;
            else if (r < 6) b = (m_ref + MODV - 1) % MODV;
            else if (r < 7) b = m_ref;
            else            b = int'($urandom_range(0, MODV - 1));
            c = ($urandom_range(0, 99) < 2);
            v = ($urandom_range(0, 99) < 85);
            drive("rand", c, v, gray_of(b));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
